// File: rtl/cvm_sequencer.sv
// Run sequencer for the covariance-matrix datapath: warm-up, accumulation,
// readback of the upper-triangle elements and streaming of them as one frame.
module cvm_sequencer #(
  parameter int NCH    = 4,
  parameter int NT     = 2,
  parameter int RD_LAT = 1,
  parameter int WARM_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_start,
  input  logic              cmd_abort,
  input  logic              cfg_cont,
  input  logic [1:0]        cfg_sel,
  input  logic [11:0]       cfg_nstat,
  input  logic [WARM_W-1:0] cfg_warmup,
  output logic              cvm_start,
  output logic [1:0]        cvm_sel,
  output logic [11:0]       cvm_nstat,
  input  logic              cvm_ready,
  output logic [31:0]       cvm_rd_addr,
  input  logic [31:0]       cvm_rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [31:0]       m_data,
  output logic [15:0]       m_index,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic [15:0]       frame_cnt
);

  localparam int MSIZE    = NT * NCH;
  localparam int ELEMENTS = (MSIZE * MSIZE + MSIZE) / 2;

  localparam logic [15:0] LAST_K   = 16'(ELEMENTS - 1);
  localparam logic [2:0]  LAT_INIT = 3'(RD_LAT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WARM  = 3'd1;
  localparam logic [2:0] S_ACCUM = 3'd2;
  localparam logic [2:0] S_RADDR = 3'd3;
  localparam logic [2:0] S_RWAIT = 3'd4;
  localparam logic [2:0] S_OUT   = 3'd5;
  localparam logic [2:0] S_GAP   = 3'd6;

  logic [2:0]        state;
  logic [WARM_W-1:0] warm_cnt;
  logic [2:0]        lat_cnt;
  logic              gap_cnt;
  logic              cont_q;
  logic [15:0]       k;

  logic last_xfer;

  assign last_xfer = (state == S_OUT) && m_ready && (k == LAST_K);

  // Control outputs decode straight from the state register, so an abort or
  // reset drops them in the very cycle the state returns to IDLE.
  assign cvm_start = (state == S_ACCUM) || (state == S_RADDR) ||
                     (state == S_RWAIT) || (state == S_OUT);
  assign m_valid   = (state == S_OUT);
  assign m_last    = (state == S_OUT) && (k == LAST_K);
  assign m_index   = k;
  assign busy      = (state != S_IDLE);

  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; a blocking = would leak new values mid-block.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      warm_cnt    <= '0;
      lat_cnt     <= '0;
      gap_cnt     <= 1'b0;
      cont_q      <= 1'b0;
      k           <= '0;
      cvm_sel     <= '0;
      cvm_nstat   <= '0;
      cvm_rd_addr <= '0;
      m_data      <= '0;
      frame_cnt   <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;

      if (state != S_IDLE && cmd_abort) begin
        // Abort wins over everything except a last beat already on the bus.
        state <= S_IDLE;
        if (last_xfer) begin
          frame_cnt <= frame_cnt + 16'd1;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (cmd_start && !cmd_abort) begin
              cvm_sel   <= cfg_sel;
              cvm_nstat <= cfg_nstat;
              cont_q    <= cfg_cont;
              if (cfg_warmup == '0) begin
                state <= S_ACCUM;
              end else begin
                warm_cnt <= cfg_warmup - WARM_W'(1);
                state    <= S_WARM;
              end
            end
          end

          S_WARM: begin
            if (warm_cnt == '0) begin
              state <= S_ACCUM;
            end else begin
              warm_cnt <= warm_cnt - WARM_W'(1);
            end
          end

          S_ACCUM: begin
            if (cvm_ready) begin
              k           <= '0;
              cvm_rd_addr <= '0;
              state       <= S_RADDR;
            end
          end

          S_RADDR: begin
            lat_cnt <= LAT_INIT;
            state   <= S_RWAIT;
          end

          S_RWAIT: begin
            if (lat_cnt == 3'd0) begin
              m_data <= cvm_rd_data;
              state  <= S_OUT;
            end else begin
              lat_cnt <= lat_cnt - 3'd1;
            end
          end

          S_OUT: begin
            if (m_ready) begin
              if (k == LAST_K) begin
                frame_cnt <= frame_cnt + 16'd1;
                gap_cnt   <= 1'b0;
                state     <= S_GAP;
              end else begin
                k           <= k + 16'd1;
                cvm_rd_addr <= {16'd0, k + 16'd1};
                state       <= S_RADDR;
              end
            end
          end

          S_GAP: begin
            if (gap_cnt) begin
              if (cont_q) begin
                state <= S_ACCUM;
              end else begin
                state <= S_IDLE;
                done  <= 1'b1;
              end
            end else begin
              gap_cnt <= 1'b1;
            end
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cvm_sequencer.sv
// Directed-plus-random bench for cvm_sequencer: a 2x1 datapath (3 elements)
// at read latency 1 and a second instance at read latency 3.
module tb_cvm_sequencer;

  localparam int E = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int fc    = 0;

  logic        reset, cmd_start, cmd_abort, cfg_cont, cvm_ready, m_ready;
  logic [1:0]  cfg_sel;
  logic [11:0] cfg_nstat;
  logic [7:0]  cfg_warmup;
  logic [31:0] cvm_rd_data;
  logic        cvm_start, m_valid, m_last, busy, done;
  logic [1:0]  cvm_sel;
  logic [11:0] cvm_nstat;
  logic [31:0] cvm_rd_addr, m_data;
  logic [15:0] m_index, frame_cnt;

  logic        cmd_start_b, m_ready_b;
  logic [31:0] cvm_rd_data_b;
  logic        cvm_start_b, m_valid_b, m_last_b, busy_b, done_b;
  logic [1:0]  cvm_sel_b;
  logic [11:0] cvm_nstat_b;
  logic [31:0] cvm_rd_addr_b, m_data_b;
  logic [15:0] m_index_b, frame_cnt_b;

  logic [31:0] rom [4];
  logic [31:0] p1, p2, p3;

  cvm_sequencer #(.NCH(2), .NT(1), .RD_LAT(1), .WARM_W(8)) dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .cfg_cont(cfg_cont), .cfg_sel(cfg_sel), .cfg_nstat(cfg_nstat), .cfg_warmup(cfg_warmup),
    .cvm_start(cvm_start), .cvm_sel(cvm_sel), .cvm_nstat(cvm_nstat), .cvm_ready(cvm_ready),
    .cvm_rd_addr(cvm_rd_addr), .cvm_rd_data(cvm_rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_index(m_index), .m_last(m_last),
    .busy(busy), .done(done), .frame_cnt(frame_cnt)
  );

  cvm_sequencer #(.NCH(2), .NT(1), .RD_LAT(3), .WARM_W(8)) dut_b (
    .clk(clk), .reset(reset), .cmd_start(cmd_start_b), .cmd_abort(1'b0),
    .cfg_cont(cfg_cont), .cfg_sel(cfg_sel), .cfg_nstat(cfg_nstat), .cfg_warmup(cfg_warmup),
    .cvm_start(cvm_start_b), .cvm_sel(cvm_sel_b), .cvm_nstat(cvm_nstat_b), .cvm_ready(cvm_ready),
    .cvm_rd_addr(cvm_rd_addr_b), .cvm_rd_data(cvm_rd_data_b),
    .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b), .m_index(m_index_b), .m_last(m_last_b),
    .busy(busy_b), .done(done_b), .frame_cnt(frame_cnt_b)
  );

  // Readback memories: a one-cycle table lookup, and a three-stage addr+100 pipe.
  always @(posedge clk) cvm_rd_data <= rom[cvm_rd_addr[1:0]];
  always @(posedge clk) begin
    p1 <= cvm_rd_addr_b + 32'd100;
    p2 <= p1;
    p3 <= p2;
  end
  assign cvm_rd_data_b = p3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_run(input logic [1:0] sel, input logic [11:0] nstat,
                           input logic [7:0] warm, input logic cont);
    cfg_sel    = sel;
    cfg_nstat  = nstat;
    cfg_warmup = warm;
    cfg_cont   = cont;
    cmd_start  = 1'b1;
    tick();
    cmd_start  = 1'b0;
  endtask

  task automatic check_reset_outs();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_cvm_start", 32'(cvm_start), 0);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_last", 32'(m_last), 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_index", 32'(m_index), 0);
    check("rst_rd_addr", cvm_rd_addr, 0);
    check("rst_frame_cnt", 32'(frame_cnt), 0);
    check("rst_sel", 32'(cvm_sel), 0);
    check("rst_nstat", 32'(cvm_nstat), 0);
  endtask

  // Consume one frame; the expected stream is element k carrying rom[k].
  task automatic collect_frame(input int stall_beat, input int stall_len,
                               input bit rnd, input bit abort_last);
    int beats = 0;
    int stalled = 0;
    int guard = 0;
    bit hold = 1'b0;
    logic [31:0] hd;
    logic [15:0] hi;
    while (guard < 300 && beats < E) begin
      tick();
      guard++;
      cmd_abort = 1'b0;
      if (hold) begin
        check("hold_valid", 32'(m_valid), 1);
        check("hold_data", m_data, hd);
        check("hold_index", 32'(m_index), 32'(hi));
      end
      if (m_valid && beats == stall_beat && stalled < stall_len) begin
        m_ready = 1'b0;
        stalled++;
      end else if (rnd) begin
        m_ready = 1'($urandom_range(0, 1));
      end else begin
        m_ready = 1'b1;
      end
      hold = m_valid && !m_ready;
      hd   = m_data;
      hi   = m_index;
      if (m_valid && m_ready) begin
        check("beat_index", 32'(m_index), beats);
        check("beat_data", m_data, rom[beats]);
        check("beat_last", 32'(m_last), 32'(beats == E - 1));
        beats++;
        if (beats == E && abort_last) cmd_abort = 1'b1;
      end
    end
    check("frame_beats", beats, E);
    check("stall_cycles", stalled, (stall_beat >= 0) ? stall_len : 0);
  endtask

  // Single-shot end: two GAP cycles then IDLE with a one-cycle done.
  task automatic finish_single();
    int n = 0;
    fc++;
    do begin
      tick();
      n++;
    end while (!done && n < 8);
    check("done_latency", n, 3);
    check("end_frame_cnt", 32'(frame_cnt), fc);
    check("end_busy", 32'(busy), 0);
    check("end_cvm_start", 32'(cvm_start), 0);
    tick();
    check("done_width", 32'(done), 0);
  endtask

  task automatic gap_cont();
    int lows = 0;
    tick();
    while (!cvm_start && lows < 8) begin
      lows++;
      tick();
    end
    check("gap_len", lows, 2);
    check("cont_frame_cnt", 32'(frame_cnt), fc);
    check("cont_busy", 32'(busy), 1);
  endtask

  initial begin
    int seen;
    int nb;
    int guard;
    logic [11:0] ns;

    reset = 1'b1; cmd_start = 1'b0; cmd_abort = 1'b0; cfg_cont = 1'b0;
    cfg_sel = 2'd0; cfg_nstat = 12'd0; cfg_warmup = 8'd0;
    cvm_ready = 1'b0; m_ready = 1'b1; cmd_start_b = 1'b0; m_ready_b = 1'b1;
    for (int i = 0; i < 4; i++) rom[i] = $urandom;
    repeat (3) tick();
    check_reset_outs();
    reset = 1'b0;
    tick();

    // Basic single frame with a 3-cycle warm-up and late cvm_ready.
    ns = 12'($urandom);
    cfg_sel = 2'd2; cfg_nstat = ns; cfg_warmup = 8'd3; cfg_cont = 1'b0;
    cmd_start = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      cmd_start = 1'b0;
      check("warm_cvm_start", 32'(cvm_start), 32'(i == 4));
      if (i == 1) begin
        check("latched_sel", 32'(cvm_sel), 2);
        check("latched_nstat", 32'(cvm_nstat), 32'(ns));
        check("run_busy", 32'(busy), 1);
      end
    end
    repeat (16) tick();
    check("accum_wait_start", 32'(cvm_start), 1);
    check("accum_wait_valid", 32'(m_valid), 0);
    cvm_ready = 1'b1;
    collect_frame(-1, 0, 1'b0, 1'b0);
    finish_single();

    // Back-pressure on beat 1 for five cycles.
    start_run(2'd2, ns, 8'd3, 1'b0);
    collect_frame(1, 5, 1'b0, 1'b0);
    finish_single();

    // Continuous mode, three frames, cfg_cont dropped mid-run, then abort.
    start_run(2'd1, 12'($urandom), 8'd0, 1'b1);
    cfg_cont = 1'b0;
    for (int f = 0; f < 3; f++) begin
      collect_frame(-1, 0, 1'b1, 1'b0);
      fc++;
      gap_cont();
    end
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_cvm_start", 32'(cvm_start), 0);
    check("abort_m_valid", 32'(m_valid), 0);
    check("abort_frame_cnt", 32'(frame_cnt), fc);
    seen = int'(done);
    repeat (4) begin
      tick();
      seen = seen | int'(done);
    end
    check("abort_no_done", seen, 0);

    // Abort coinciding with the last handshake still counts the frame.
    start_run(2'd0, 12'd7, 8'd0, 1'b1);
    collect_frame(-1, 0, 1'b0, 1'b1);
    tick();
    cmd_abort = 1'b0;
    fc++;
    check("lastabort_frame_cnt", 32'(frame_cnt), fc);
    check("lastabort_busy", 32'(busy), 0);
    seen = int'(done);
    repeat (4) begin
      tick();
      seen = seen | int'(done);
    end
    check("lastabort_no_done", seen, 0);

    // Simultaneous start and abort in IDLE: stay idle.
    cmd_start = 1'b1;
    cmd_abort = 1'b1;
    tick();
    cmd_start = 1'b0;
    cmd_abort = 1'b0;
    check("startabort_busy", 32'(busy), 0);
    tick();
    check("startabort_busy2", 32'(busy), 0);

    // Zero warm-up, config changes and restart requests mid-run are ignored.
    start_run(2'd0, 12'd5, 8'd0, 1'b0);
    check("nowarm_cvm_start", 32'(cvm_start), 1);
    cfg_sel = 2'd3; cfg_nstat = 12'd9; cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    check("midrun_sel", 32'(cvm_sel), 0);
    check("midrun_nstat", 32'(cvm_nstat), 5);
    collect_frame(-1, 0, 1'b0, 1'b0);
    finish_single();
    check("idle_sel", 32'(cvm_sel), 0);
    start_run(2'd3, 12'd9, 8'd2, 1'b0);
    check("next_run_sel", 32'(cvm_sel), 3);
    cmd_abort = 1'b1;
    tick();
    cmd_abort = 1'b0;
    check("cleanup_busy", 32'(busy), 0);

    // Reset while waiting on read data.
    start_run(2'd1, 12'd3, 8'd0, 1'b0);
    tick();
    check("raddr_addr", cvm_rd_addr, 0);
    check("raddr_valid", 32'(m_valid), 0);
    tick();
    check("rwait_start", 32'(cvm_start), 1);
    check("rwait_valid", 32'(m_valid), 0);
    reset = 1'b1;
    tick();
    check_reset_outs();
    reset = 1'b0;
    fc = 0;
    start_run(2'd2, 12'd4, 8'd1, 1'b0);
    collect_frame(-1, 0, 1'b1, 1'b0);
    finish_single();

    // Read latency 3 on the second instance: data = address + 100.
    cfg_cont = 1'b0; cfg_warmup = 8'd2;
    cmd_start_b = 1'b1;
    tick();
    cmd_start_b = 1'b0;
    nb = 0;
    guard = 0;
    while (nb < E && guard < 100) begin
      tick();
      guard++;
      if (m_valid_b) begin
        check("lat3_data", m_data_b, 32'(100 + nb));
        check("lat3_index", 32'(m_index_b), nb);
        nb++;
      end
    end
    check("lat3_beats", nb, E);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cvm_sequencer.md
CVM_SEQUENCER -- requirements
Module: cvm_sequencer

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of antenna channels of the covariance datapath.
REQ-002 SHALL have parameter NT, default 2, meaning time depth; MSIZE = NT*NCH and ELEMENTS = (MSIZE*MSIZE+MSIZE)/2 are derived localparams.
REQ-003 SHALL have parameter RD_LAT, default 1, meaning cycles from cvm_rd_addr change to valid cvm_rd_data (legal range 1..4).
REQ-004 SHALL have parameter WARM_W, default 8, meaning width of the warm-up counter.
REQ-005 SHALL have port clk, input, 1, meaning the single clock.
REQ-006 SHALL have port reset, input, 1, meaning the reset, which is synchronous and active-high.
REQ-007 SHALL have port cmd_start, input, 1, meaning a single-cycle run request.
REQ-008 SHALL have port cmd_abort, input, 1, meaning a single-cycle abort request.
REQ-009 SHALL have port cfg_cont, input, 1, meaning continuous mode: 1 = repeat frames until abort.
REQ-010 SHALL have ports cfg_sel (input, 2), cfg_nstat (input, 12) and cfg_warmup (input, WARM_W), meaning mux mode, statistics length and pre-start delay in cycles.
REQ-011 SHALL have ports cvm_start (output, 1), cvm_sel (output, 2), cvm_nstat (output, 12), cvm_ready (input, 1), cvm_rd_addr (output, 32) and cvm_rd_data (input, 32), meaning the datapath control and readback ports.
REQ-012 SHALL have ports m_valid (output, 1), m_ready (input, 1), m_data (output, 32), m_index (output, 16) and m_last (output, 1), meaning the result stream.
REQ-013 SHALL have ports busy (output, 1), done (output, 1) and frame_cnt (output, 16), meaning activity flag, end-of-run pulse and number of completed frames.

Function
REQ-014 SHALL implement states IDLE, WARM, ACCUM, RADDR, RWAIT, OUT and GAP.
REQ-015 In IDLE, cmd_start SHALL latch cfg_sel, cfg_nstat, cfg_warmup and cfg_cont, then move to WARM; latched values SHALL drive cvm_sel/cvm_nstat for the whole run.
REQ-016 WARM SHALL last exactly cfg_warmup cycles (0 = skip directly to ACCUM), with cvm_start low.
REQ-017 cvm_start SHALL be 1 in ACCUM, RADDR, RWAIT and OUT, and 0 in all other states.
REQ-018 ACCUM SHALL wait for cvm_ready=1, then move to RADDR with element index k=0.
REQ-019 RADDR SHALL drive cvm_rd_addr=k for one cycle; RWAIT SHALL hold the address for RD_LAT cycles, then register cvm_rd_data into m_data and enter OUT.
REQ-020 OUT SHALL hold m_valid=1 with stable m_data, m_index=k and m_last=(k==ELEMENTS-1) until m_ready=1; the transfer completes in the cycle m_valid&m_ready.
REQ-021 After a non-last transfer SHALL go to RADDR with k+1; after the last transfer SHALL increment frame_cnt (wrapping at 16 bits) and enter GAP.
REQ-022 GAP SHALL last exactly 2 cycles with cvm_start=0, then enter ACCUM if the latched cont=1, else IDLE, with a 1-cycle done pulse on IDLE entry.
REQ-023 cvm_rd_addr SHALL hold its last value outside RADDR/RWAIT.
REQ-024 busy SHALL be 0 only in IDLE.
REQ-025 cmd_start outside IDLE SHALL be ignored; cfg_* changes during a run SHALL have no effect until the next cmd_start.
REQ-026 cmd_abort in any non-IDLE state SHALL force IDLE on the next cycle and drop m_valid and cvm_start there; done SHALL NOT pulse and frame_cnt SHALL NOT change.
REQ-027 cmd_abort and cmd_start in the same cycle in IDLE: abort SHALL win and the state SHALL remain IDLE.
REQ-028 cmd_abort in the same cycle as the last OUT handshake: the handshake SHALL complete (frame_cnt increments), then the block SHALL go to IDLE without done.
REQ-029 cvm_ready falling while outside ACCUM SHALL be ignored.

Reset
REQ-030 While reset=1 at a clk edge, the state SHALL become IDLE and k, cvm_rd_addr, m_data, m_index and frame_cnt SHALL become 0; cvm_start, m_valid, m_last, busy and done SHALL become 0; cvm_sel and cvm_nstat SHALL become 0.
REQ-031 Reset mid-run SHALL discard the run with no done pulse; the first cmd_start after release SHALL be accepted normally.

Verification
REQ-032 NCH=2, NT=1, RD_LAT=1, warmup=3, cont=0, m_ready=1; pulse cmd_start; raise cvm_ready 20 cycles later -> cvm_start rises 4 cycles after cmd_start; 3 beats with m_index 0,1,2, m_last only on index 2; then done pulse, frame_cnt=1, busy=0.
REQ-033 Same configuration with m_ready low for 5 cycles during beat 1 -> m_valid, m_data and m_index=1 held stable throughout; no beat lost or duplicated.
REQ-034 cont=1 -> after each frame, cvm_start is low exactly 2 cycles before reasserting; frame_cnt counts 1,2,3; then cmd_abort -> IDLE next cycle, no done pulse.
REQ-035 Change cfg_sel from 0 to 3 mid-run -> cvm_sel stays 0 until the next cmd_start.
REQ-036 Assert reset in RWAIT -> all outputs at reset values next cycle; a new run then completes with frame_cnt=1.
REQ-037 RD_LAT=3 with a model returning data = address+100 -> m_data sequence 100,101,102.
